// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 2-flop synchroniser, oversampled bit timing,
// runtime character format, registered character and error flags.
module uart_rx_deserializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [DIV_WIDTH-1:0]  baudDivisor,
    input  logic [4:0]            overSampling,
    input  logic [3:0]            dataType,
    input  logic                  parityEnable,
    input  logic                  parityType,
    input  logic [1:0]            stopBits,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  dataValid,
    output logic                  parityError,
    output logic                  framingError,
    output logic                  busy
);

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CHAR_W = 8;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_sync_q, rx_prev_q, rx_prev_d;
    logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [CHAR_W-1:0]     shift_q, shift_d;
    logic                  par_flag_q, par_flag_d;
    logic                  frm_flag_q, frm_flag_d;
    logic                  is13_q, is13_d;
    logic [IDX_W-1:0]      char_last_q, char_last_d;
    logic                  par_en_q, par_en_d;
    logic                  par_odd_q, par_odd_d;
    logic                  two_stop_q, two_stop_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  framing_error_q, framing_error_d;
    logic                  busy_q, busy_d;

    logic [DIV_WIDTH-1:0]  div_eff_c;
    logic                  tick_c;
    logic [CNT_W-1:0]      half_m1_c, osr_m1_c;
    logic                  full_c;
    logic [3:0]            width_c;

    // Tick generator and per-frame timing constants
    always_comb begin
        div_eff_c = (baudDivisor == '0) ? DIV_WIDTH'(1) : baudDivisor;
        tick_c    = (div_cnt_q >= (div_eff_c - DIV_WIDTH'(1)));
        half_m1_c = is13_q ? 5'd5  : 5'd7;
        osr_m1_c  = is13_q ? 5'd12 : 5'd15;
        full_c    = tick_c && (tick_cnt_q == osr_m1_c);
        if (dataType < 4'd5)      width_c = 4'd5;
        else if (dataType > 4'd8) width_c = 4'd8;
        else                      width_c = dataType;
    end

    // Next-state, counters, config latch and output register inputs
    always_comb begin
        state_d         = state_q;
        rx_prev_d       = (state_q == DONE) ? rx_prev_q : rx_sync_q;
        div_cnt_d       = tick_c ? '0 : div_cnt_q + DIV_WIDTH'(1);
        tick_cnt_d      = tick_c ? tick_cnt_q + 5'd1 : tick_cnt_q;
        bit_idx_d       = bit_idx_q;
        stop_idx_d      = stop_idx_q;
        shift_d         = shift_q;
        par_flag_d      = par_flag_q;
        frm_flag_d      = frm_flag_q;
        is13_d          = is13_q;
        char_last_d     = char_last_q;
        par_en_d        = par_en_q;
        par_odd_d       = par_odd_q;
        two_stop_d      = two_stop_q;
        rx_data_d       = rx_data_q;
        data_valid_d    = 1'b0;
        parity_error_d  = parity_error_q;
        framing_error_d = framing_error_q;
        busy_d          = busy_q;

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d     = START;
                    div_cnt_d   = '0;
                    bit_idx_d   = '0;
                    stop_idx_d  = 1'b0;
                    shift_d     = '0;
                    par_flag_d  = 1'b0;
                    frm_flag_d  = 1'b0;
                    is13_d      = (overSampling == 5'd13);
                    char_last_d = IDX_W'(width_c - 4'd1);
                    par_en_d    = parityEnable;
                    par_odd_d   = parityType;
                    two_stop_d  = (stopBits == 2'd2);
                    busy_d      = 1'b1;
                end
            end
            START: begin
                if (tick_c && (tick_cnt_q == half_m1_c)) begin
                    tick_cnt_d = '0;
                    if (!rx_sync_q) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            DATA: begin
                if (full_c) begin
                    tick_cnt_d         = '0;
                    shift_d[bit_idx_q] = rx_sync_q;
                    if (bit_idx_q == char_last_q) begin
                        bit_idx_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (full_c) begin
                    tick_cnt_d = '0;
                    if (rx_sync_q != ((^shift_q) ^ par_odd_q)) par_flag_d = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (full_c) begin
                    tick_cnt_d = '0;
                    if (!rx_sync_q) frm_flag_d = 1'b1;
                    if (stop_idx_q == two_stop_q) begin
                        state_d         = DONE;
                        data_valid_d    = 1'b1;
                        busy_d          = 1'b0;
                        rx_data_d       = DATA_WIDTH'(shift_q);
                        parity_error_d  = par_flag_q;
                        framing_error_d = frm_flag_q | !rx_sync_q;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, synchroniser and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            rx_meta_q       <= 1'b1;
            rx_sync_q       <= 1'b1;
            rx_prev_q       <= 1'b1;
            div_cnt_q       <= '0;
            tick_cnt_q      <= '0;
            bit_idx_q       <= '0;
            stop_idx_q      <= 1'b0;
            shift_q         <= '0;
            par_flag_q      <= 1'b0;
            frm_flag_q      <= 1'b0;
            is13_q          <= 1'b0;
            char_last_q     <= 3'd7;
            par_en_q        <= 1'b0;
            par_odd_q       <= 1'b0;
            two_stop_q      <= 1'b0;
            rx_data_q       <= '0;
            data_valid_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rx_meta_q       <= rx;
            rx_sync_q       <= rx_meta_q;
            rx_prev_q       <= rx_prev_d;
            div_cnt_q       <= div_cnt_d;
            tick_cnt_q      <= tick_cnt_d;
            bit_idx_q       <= bit_idx_d;
            stop_idx_q      <= stop_idx_d;
            shift_q         <= shift_d;
            par_flag_q      <= par_flag_d;
            frm_flag_q      <= frm_flag_d;
            is13_q          <= is13_d;
            char_last_q     <= char_last_d;
            par_en_q        <= par_en_d;
            par_odd_q       <= par_odd_d;
            two_stop_q      <= two_stop_d;
            rx_data_q       <= rx_data_d;
            data_valid_q    <= data_valid_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
            busy_q          <= busy_d;
        end
    end

    assign rxData       = rx_data_q;
    assign dataValid    = data_valid_q;
    assign parityError  = parity_error_q;
    assign framingError = framing_error_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: directed frames with
// hand-computed characters, parity bits and expected error flags.
module tb_uart_rx_deserializer;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned DIV_WIDTH  = 16;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  rx;
    logic [DIV_WIDTH-1:0]  baudDivisor;
    logic [4:0]            overSampling;
    logic [3:0]            dataType;
    logic                  parityEnable;
    logic                  parityType;
    logic [1:0]            stopBits;
    logic [DATA_WIDTH-1:0] rxData;
    logic                  dataValid;
    logic                  parityError;
    logic                  framingError;
    logic                  busy;

    uart_rx_deserializer #(.DATA_WIDTH(DATA_WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clk          (clk),
        .reset        (reset_n),
        .rx           (rx),
        .baudDivisor  (baudDivisor),
        .overSampling (overSampling),
        .dataType     (dataType),
        .parityEnable (parityEnable),
        .parityType   (parityType),
        .stopBits     (stopBits),
        .rxData       (rxData),
        .dataValid    (dataValid),
        .parityError  (parityError),
        .framingError (framingError),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_valid_cyc = -1;
    int   valid_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every dataValid pulse pops one expected character
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n === 1'b1 && dataValid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual rxData=0x%0h required=no pulse", rxData);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_rxData"}, 32'(rxData), 32'(e.data));
                check({e.name, "_parityError"}, 32'(parityError), 32'(e.perr));
                check({e.name, "_framingError"}, 32'(framingError), 32'(e.ferr));
            end
        end
    end

    task automatic expect_char(input logic [7:0] d, input logic pe, input logic fe, input string name);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int div, input int osr, input int dt, input logic pe,
                           input logic pt, input int sb);
        baudDivisor  = DIV_WIDTH'(div);
        overSampling = 5'(osr);
        dataType     = 4'(dt);
        parityEnable = pe;
        parityType   = pt;
        stopBits     = 2'(sb);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic has_par,
                              input logic par_bit, input int nstop, input logic [1:0] stop_vals,
                              input int cpb);
        drive(1'b0, cpb);
        for (int i = 0; i < nbits; i++) drive(data[i], cpb);
        if (has_par) drive(par_bit, cpb);
        for (int i = 0; i < nstop; i++) drive(stop_vals[i], cpb);
        rx = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rxData"}, 32'(rxData), 32'h0);
        check({tag, "_dataValid"}, 32'(dataValid), 32'h0);
        check({tag, "_parityError"}, 32'(parityError), 32'h0);
        check({tag, "_framingError"}, 32'(framingError), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int start_cyc;
        int lat;
        int saved_cnt;
        int budget;

        reset_n = 1'b0;
        rx      = 1'b1;
        set_cfg(1, 16, 8, 1'b1, 1'b0, 1);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_init");
        reset_n = 1'b1;
        drive(1'b1, 10);

        // 0xA5, even parity (four ones -> parity 0), latency from start edge
        expect_char(8'hA5, 1'b0, 1'b0, "t1_A5");
        start_cyc = cyc;
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1, 2'b11, 16);
        drive(1'b1, 20);
        lat = last_valid_cyc - start_cyc;
        checks++;
        if (lat < 169 || lat > 172) begin
            failures++;
            $display("FAIL t1_latency actual=%0d clks required=170+-1", lat);
        end

        // 0x5A with wrong parity bit 1 (correct even parity is 0)
        expect_char(8'h5A, 1'b1, 1'b0, "t2_5A_badpar");
        send_frame(8'h5A, 8, 1'b1, 1'b1, 1, 2'b11, 16);
        drive(1'b1, 20);

        // divisor 3, OSR 13, 7-bit, no parity, 2 stops with second stop low
        set_cfg(3, 13, 7, 1'b0, 1'b0, 2);
        expect_char(8'h41, 1'b0, 1'b1, "t3_41_frm");
        send_frame(8'h41, 7, 1'b0, 1'b0, 2, 2'b01, 39);
        drive(1'b1, 100);

        // 4-clk glitch is rejected after HALF ticks
        set_cfg(1, 16, 8, 1'b1, 1'b0, 1);
        saved_cnt = valid_cnt;
        drive(1'b0, 4);
        drive(1'b1, 2);
        check("t4_busy_during_glitch", 32'(busy), 32'h1);
        drive(1'b1, 20);
        check("t4_busy_after_glitch", 32'(busy), 32'h0);
        check("t4_no_pulse", 32'(valid_cnt), 32'(saved_cnt));
        expect_char(8'h3C, 1'b0, 1'b0, "t4_3C");
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1, 2'b11, 16);
        drive(1'b1, 20);

        // reset in the middle of 0x77, then 0x12
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b1, 16);
        drive(1'b1, 8);
        check("t6_busy_before_reset", 32'(busy), 32'h1);
        reset_n = 1'b0;
        rx      = 1'b1;
        #3;
        check_reset_outputs("t6_in_reset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("t6_in_reset_late");
        reset_n = 1'b1;
        drive(1'b1, 30);
        expect_char(8'h12, 1'b0, 1'b0, "t6_12");
        send_frame(8'h12, 8, 1'b1, 1'b0, 1, 2'b11, 16);
        drive(1'b1, 20);

        // 5-bit odd parity, back-to-back with no idle bits
        set_cfg(1, 16, 5, 1'b1, 1'b1, 1);
        expect_char(8'h1F, 1'b0, 1'b0, "t5_1F");
        expect_char(8'h00, 1'b0, 1'b0, "t5_00");
        send_frame(8'h1F, 5, 1'b1, 1'b0, 1, 2'b11, 16);
        send_frame(8'h00, 5, 1'b1, 1'b1, 1, 2'b11, 16);
        drive(1'b1, 30);

        budget = 2000;
        while (sb_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive-side UART stage. Consumes the serial `rx` line driven by the transmitter and produces parallel characters plus error flags for the monitor and scoreboard path.
- Oversampled at 16x or 13x, with runtime-configurable data width (5–8), parity enable/type and stop bits (1/2).
- Frame format: START_BIT=0, STOP_BIT=1, LSB first.

Parameters:
- DATA_WIDTH, 8, width of the rxData output (max character width).
- DIV_WIDTH, 16, width of the baudDivisor input.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high; asynchronous to clk.
- baudDivisor  input  DIV_WIDTH  clk cycles per oversample tick; 0 treated as 1.
- overSampling  input  5  16 or 13; any other value treated as 16.
- dataType  input  4  character bits 5..8; values <5 treated as 5, >8 treated as 8.
- parityEnable  input  1  1 = a parity bit follows the data.
- parityType  input  1  0 = EVEN_PARITY, 1 = ODD_PARITY.
- stopBits  input  2  1 = ONE_BIT, 2 = TWO_BIT; other values treated as 1.
- rxData  output  DATA_WIDTH  received character, zero-extended above dataType.
- dataValid  output  1  one-clk pulse, character complete.
- parityError  output  1  valid with dataValid.
- framingError  output  1  valid with dataValid.
- busy  output  1  high from start detection until dataValid.

Behaviour:
- Reset (reset=0, async): state IDLE, all counters 0, synchroniser flops = 1. Outputs: rxData=0, dataValid=0, parityError=0, framingError=0, busy=0. Deasserting reset mid-frame discards the frame; no dataValid is produced for it.
- Synchroniser: rx passes through 2 flops (rxSync). All decisions use rxSync.
- Tick generator: a free-running counter produces a 1-clk sampleTick every max(baudDivisor,1) clks. It is reset to 0 on entry to START so that bit timing is phase-aligned to the start edge.
- Config latch: overSampling, dataType, parityEnable, parityType and stopBits are captured on the clk that leaves IDLE. They are held constant for the whole frame; input changes mid-frame have no effect.
- Let OSR be the latched oversampling rate. HALF = OSR/2, i.e. 8 for OSR=16 and 6 for OSR=13.
- IDLE: on rxSync falling (previous 1, current 0) -> START, busy=1.
- START: count HALF ticks, then sample rxSync.
  - 0 -> DATA, reset tick count.
  - 1 -> IDLE (glitch rejected), busy=0, no output.
- DATA: sample every OSR ticks (mid-bit). Shift LSB first into bit index 0..dataType-1. After dataType samples:
  - parityEnable=1 -> PARITY.
  - otherwise -> STOP.
- PARITY: sample after OSR ticks.
  - Expected bit = XOR(data bits) for EVEN, ~XOR for ODD.
  - Mismatch sets the internal parity flag.
  - Then -> STOP.
- STOP: sample after OSR ticks, once or twice per stopBits. Any stop sample = 0 sets the internal framing flag.
  - After the final stop sample -> DONE.
  - No early exit on a bad stop bit; all stop bits are always timed.
- DONE (1 clk):
  - Drive rxData, parityError and framingError.
  - dataValid=1 for exactly this clk, busy=0, then -> IDLE.
  - rxData, parityError and framingError hold their values until the next DONE.
- Latency: dataValid asserts on the clk immediately after the sampleTick carrying the final stop sample.
- Back-to-back frames: IDLE is re-entered with rxSync=1. A start edge arriving in the DONE clk is detected on the following clk; the timing slip is at most 1 clk. This requires no idle gap.
- Break (line held 0): data=0 and framingError=1 are reported once. No new start is detected until rxSync has returned to 1 and falls again.
- Width rules:
  - Tick counters are 5 bits.
  - The bit index counter is 3 bits and counts 0..dataType-1.
  - rxData bits [DATA_WIDTH-1:dataType] are forced to 0.
- No buffering. A consumer that misses the dataValid pulse loses the character; the overrun case is not flagged.

Test Plan:
- divisor=1, OSR=16, 8-bit, even parity, 1 stop; send 0xA5 with parity bit 0 -> one dataValid pulse, rxData=0xA5, parityError=0, framingError=0. dataValid occurs 2+8+16*10 tick-aligned clks after the start edge (±1 clk).
- Same config, send 0x5A with a wrong parity bit 1 -> rxData=0x5A, parityError=1, framingError=0.
- divisor=3, OSR=13, 7-bit, parity disabled, 2 stop; send 0x41 with the second stop bit 0 -> rxData=0x41, framingError=1. Frame length is 13*3*10 clks.
- 4-clk low glitch on rx (divisor=1, OSR=16) -> no dataValid, busy returns to 0 after HALF ticks, and a subsequent valid frame 0x3C is received correctly.
- 5-bit data, odd parity; send 0x1F then 0x00 back-to-back with 0 idle bits -> two pulses, rxData=0x1F then 0x00, all error flags 0, upper rxData bits 0.
- Assert reset during DATA of frame 0x77, release, then send 0x12 -> every output reads its reset value while reset is low; the aborted frame produces no pulse; the next pulse carries rxData=0x12.
